// File: rtl/syscall_pkg.sv
// Shared constants and types for the syscall dispatch slice.
package syscall_pkg;
  localparam logic [5:0]  SYSCALL_FUNCT = 6'h0C;
  localparam logic [31:0] SC_PRINT_INT  = 32'd1;
  localparam logic [31:0] SC_EXIT       = 32'd10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO; head reads as zero while empty.
module sync_fifo_fwft #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [AW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                  cnt_q, cnt_d;
  logic                         do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = empty ? '0 : mem_q[rptr_q];
  assign count = cnt_q;

  // Guards keep the FIFO self-protecting even if a caller ignores full/empty.
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/syscall_dispatch.sv
// Syscall consumer: buffers print output, sequences halt on exit, keeps stats.
module syscall_dispatch
  import syscall_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sc_valid,
  input  logic [31:0]       sc_code,
  input  logic [DATA_W-1:0] sc_arg,
  input  logic              instr_retired,
  output logic              sc_stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halt,
  output logic              bad_code,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
);
  state_e                 state_q, state_d;
  logic                   bad_q, bad_d;
  logic [31:0]            cyc_q, cyc_d, ins_q, ins_d;
  logic                   fifo_full, fifo_empty, accept, push, pop;
  logic [$clog2(DEPTH):0] fifo_cnt;

  // Stall depends only on registered state so it never loops through out_ready.
  assign sc_stall  = fifo_full | (state_q != ST_RUN);
  assign accept    = sc_valid & ~sc_stall;
  assign push      = accept & (sc_code == SC_PRINT_INT);
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign halt      = (state_q == ST_HALTED);
  assign bad_code  = bad_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

  sync_fifo_fwft #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sc_arg),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (out_data),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    bad_d   = accept & (sc_code != SC_PRINT_INT) & (sc_code != SC_EXIT);
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    case (state_q)
      ST_RUN:   if (accept && sc_code == SC_EXIT) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_cnt == '0) state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
    if (!halt && cyc_q != '1) cyc_d = cyc_q + 32'd1;
    if (!halt && instr_retired && ins_q != '1) ins_d = ins_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      bad_q   <= 1'b0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end
endmodule

// File: tb/tb_syscall_dispatch.sv
// Directed bench for syscall_dispatch: prints, full stall, exit drain, bad code, async reset.
module tb_syscall_dispatch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sc_valid, instr_retired, out_ready;
  logic [31:0] sc_code, sc_arg;
  logic        sc_stall, out_valid, halt, bad_code;
  logic [31:0] out_data, cycle_count, instr_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  syscall_dispatch #(.DEPTH(4), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sc_valid      (sc_valid),
    .sc_code       (sc_code),
    .sc_arg        (sc_arg),
    .instr_retired (instr_retired),
    .sc_stall      (sc_stall),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .halt          (halt),
    .bad_code      (bad_code),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] code, input logic [31:0] arg);
    sc_valid = v;
    sc_code  = code;
    sc_arg   = arg;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; instr_retired = 1'b0;
    req(1'b0, 32'd0, 32'd0);
    #12;
    chk("rst_stall", {31'd0, sc_stall}, 32'd0);
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_odata", out_data, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_bad", {31'd0, bad_code}, 32'd0);
    chk("rst_cyc", cycle_count, 32'd0);
    chk("rst_ins", instr_count, 32'd0);
    rst_n = 1'b1;
    step();  // first edge after release at t=15

    // Streaming prints with ready held high.
    out_ready = 1'b1;
    req(1'b1, 32'd1, 32'd5); step();
    chk("p1_head5", out_data, 32'd5);
    chk("p1_stall", {31'd0, sc_stall}, 32'd0);
    req(1'b1, 32'd1, 32'd7); step();
    chk("p1_head7", out_data, 32'd7);
    req(1'b1, 32'd1, 32'd9); step();
    chk("p1_head9", out_data, 32'd9);
    chk("p1_stall9", {31'd0, sc_stall}, 32'd0);
    req(1'b0, 32'd0, 32'd0); step();
    chk("p1_empty", {31'd0, out_valid}, 32'd0);
    chk("p1_zero", out_data, 32'd0);
    chk("p1_cyc", cycle_count, 32'd5);

    // Fill to full with ready low; the fifth request is stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, 32'd1, 32'(i)); step();
      chk("p2_stall", {31'd0, sc_stall}, (i == 4) ? 32'd1 : 32'd0);
    end
    req(1'b1, 32'd1, 32'd5); step();
    chk("p2_hold1", out_data, 32'd1);
    chk("p2_stillfull", {31'd0, sc_stall}, 32'd1);
    out_ready = 1'b1; step();   // pop 1 only; push refused while full
    chk("p2_head2", out_data, 32'd2);
    chk("p2_unstall", {31'd0, sc_stall}, 32'd0);
    step();                     // push 5, pop 2
    req(1'b0, 32'd0, 32'd0);
    chk("p2_head3", out_data, 32'd3);
    step(); chk("p2_head4", out_data, 32'd4);
    step(); chk("p2_head5", out_data, 32'd5);
    step(); chk("p2_empty", {31'd0, out_valid}, 32'd0);

    // Unsupported code with one entry buffered.
    out_ready = 1'b0;
    req(1'b1, 32'd1, 32'd77); step();
    req(1'b1, 32'd4, 32'd0); step();
    chk("bc_pulse", {31'd0, bad_code}, 32'd1);
    chk("bc_head", out_data, 32'd77);
    chk("bc_stall", {31'd0, sc_stall}, 32'd0);
    req(1'b0, 32'd0, 32'd0); step();
    chk("bc_drop", {31'd0, bad_code}, 32'd0);
    out_ready = 1'b1; step();
    chk("bc_count1", {31'd0, out_valid}, 32'd0);

    // Async reset while draining with two entries buffered.
    out_ready = 1'b0;
    req(1'b1, 32'd1, 32'd100); step();
    req(1'b1, 32'd1, 32'd200); step();
    req(1'b1, 32'd10, 32'd0); step();
    req(1'b0, 32'd0, 32'd0);
    chk("ar_drain_stall", {31'd0, sc_stall}, 32'd1);
    chk("ar_drain_ov", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", {31'd0, out_valid}, 32'd0);
    chk("ar_halt", {31'd0, halt}, 32'd0);
    chk("ar_stall", {31'd0, sc_stall}, 32'd0);
    chk("ar_cyc", cycle_count, 32'd0);
    step();
    rst_n = 1'b1;
    chk("ar_rel_cyc", cycle_count, 32'd0);
    step();
    chk("ar_cyc1", cycle_count, 32'd1);
    chk("ar_ins0", instr_count, 32'd0);
    chk("ar_run", {31'd0, sc_stall}, 32'd0);

    // Exit behind two buffered prints; the later print must never appear.
    req(1'b1, 32'd1, 32'd11); step();
    req(1'b1, 32'd1, 32'd22); step();
    req(1'b1, 32'd10, 32'd0); step();
    chk("ex_stall", {31'd0, sc_stall}, 32'd1);
    req(1'b1, 32'd1, 32'd33); step();
    chk("ex_halt0", {31'd0, halt}, 32'd0);
    chk("ex_head11", out_data, 32'd11);
    out_ready = 1'b1; step();
    req(1'b0, 32'd0, 32'd0);
    chk("ex_head22", out_data, 32'd22);
    chk("ex_halt1", {31'd0, halt}, 32'd0);
    step();
    chk("ex_empty", {31'd0, out_valid}, 32'd0);
    chk("ex_halt2", {31'd0, halt}, 32'd0);
    step();
    chk("ex_halt", {31'd0, halt}, 32'd1);
    req(1'b1, 32'd1, 32'd33); step();
    chk("ex_no33", {31'd0, out_valid}, 32'd0);
    chk("ex_stall_h", {31'd0, sc_stall}, 32'd1);
    req(1'b0, 32'd0, 32'd0);

    // Exit on empty FIFO with an instruction retiring every cycle.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    out_ready = 1'b0; instr_retired = 1'b1;
    req(1'b1, 32'd10, 32'd0); step();
    req(1'b0, 32'd0, 32'd0);
    chk("fz_halt0", {31'd0, halt}, 32'd0);
    chk("fz_cyc1", cycle_count, 32'd1);
    chk("fz_ins1", instr_count, 32'd1);
    step();
    chk("fz_halt", {31'd0, halt}, 32'd1);
    chk("fz_cyc2", cycle_count, 32'd2);
    chk("fz_ins2", instr_count, 32'd2);
    step(); step(); step();
    chk("fz_cyc_frz", cycle_count, 32'd2);
    chk("fz_ins_frz", instr_count, 32'd2);
    chk("fz_halt_st", {31'd0, halt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
